// File: rtl/dsp_pkg.sv
// Shared DSP types and the 20-tap symmetric lowpass used by the 4x interpolator/decimator pair.
// Every polyphase branch of H sums to exactly 2^17, so each output phase has unity DC gain.
package dsp_pkg;
  localparam int N      = 20;
  localparam int L      = 4;
  localparam int N_BY_L = N / L;

  typedef logic signed [17:0] sample_t;
  typedef logic signed [35:0] acc_t;

  localparam sample_t H [N] = '{
    -18'sd3928,  -18'sd3000,  -18'sd2928,  -18'sd3000,   18'sd8000,
     18'sd20000,  18'sd7000,   18'sd45000,  18'sd85000,  18'sd110000,
     18'sd110000, 18'sd85000,  18'sd45000,  18'sd7000,   18'sd20000,
     18'sd8000,  -18'sd3000,  -18'sd2928,  -18'sd3000,  -18'sd3928
  };

  // Coefficient for branch k in phase p: H[L*k + p].
  function automatic sample_t coef(input logic [2:0] k, input logic [1:0] p);
    logic [4:0] idx;
    idx = {k, 2'b00} + {3'b000, p};
    return H[idx];
  endfunction
endpackage

// File: rtl/upsampler_if.sv
// Sample-in / interpolated-sample-out bundle for the upsampler.
interface upsampler_if;
  import dsp_pkg::*;
  logic    sam_clk_ena;
  sample_t x_in;
  sample_t y;
  logic    y_phase0;

  modport master (output sam_clk_ena, x_in, input  y, y_phase0);
  modport slave  (input  sam_clk_ena, x_in, output y, y_phase0);
endinterface

// File: rtl/upsampler_adder_tree.sv
// Registered 5-input, 3-level 36-bit sum: 5->3->2->1, odd leftovers pass through a register.
module upsampler_adder_tree
  import dsp_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  acc_t i_prod [N_BY_L],
  output acc_t o_sum
);
  acc_t r_l1 [3];
  acc_t r_l2 [2];
  acc_t r_sum;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_l1  <= '{default: '0};
      r_l2  <= '{default: '0};
      r_sum <= '0;
    end else begin
      r_l1[0] <= i_prod[0] + i_prod[1];
      r_l1[1] <= i_prod[2] + i_prod[3];
      r_l1[2] <= i_prod[4];
      r_l2[0] <= r_l1[0] + r_l1[1];
      r_l2[1] <= r_l1[2];
      r_sum   <= r_l2[0] + r_l2[1];
    end
  end

  assign o_sum = r_sum;
endmodule

// File: rtl/upsampler.sv
// 4x interpolating polyphase FIR: 5 shared multipliers cycle through 4 phases of a 20-tap filter.
// Define UPSAMPLER_SAT_EN to saturate y on accumulator overflow instead of wrapping.
module upsampler
  import dsp_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  upsampler_if.slave  bus
);
  sample_t                 r_x    [N_BY_L];
  acc_t                    r_prod [N_BY_L];
  logic [$clog2(L)-1:0]    r_p;
  logic [4:0]              r_vld_pipe;
  acc_t                    w_sum;
  sample_t                 w_y;

  // Phase restarts on every strobe; late strobes just keep wrapping over the same x.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_x        <= '{default: '0};
      r_prod     <= '{default: '0};
      r_p        <= '0;
      r_vld_pipe <= '0;
    end else begin
      if (bus.sam_clk_ena) begin
        r_x[0] <= bus.x_in;
        for (int k = 1; k < N_BY_L; k++) r_x[k] <= r_x[k-1];
        r_p <= '0;
      end else begin
        r_p <= r_p + 1'b1;
      end
      for (int k = 0; k < N_BY_L; k++)
        r_prod[k] <= acc_t'(coef(3'(k), r_p)) * acc_t'(r_x[k]);
      r_vld_pipe <= {r_vld_pipe[3:0], bus.sam_clk_ena};
    end
  end

  upsampler_adder_tree u_tree (
    .clk    (clk),
    .reset  (reset),
    .i_prod (r_prod),
    .o_sum  (w_sum)
  );

`ifdef UPSAMPLER_SAT_EN
  always_comb begin
    w_y = w_sum[34:17];
    if (w_sum[35] != w_sum[34]) w_y = w_sum[35] ? 18'sh20000 : 18'sh1FFFF;
  end
`else
  assign w_y = w_sum[34:17];
`endif

  assign bus.y        = w_y;
  assign bus.y_phase0 = r_vld_pipe[4];
endmodule

// File: tb/tb_upsampler.sv
// Bench for upsampler: sample-history reference model checked every cycle, plus literal pins.
module tb_upsampler;
  logic clk = 1'b0;
  logic reset = 1'b1;
  upsampler_if bus();

  upsampler dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  int H [20] = '{-3928, -3000, -2928, -3000, 8000, 20000, 7000, 45000, 85000, 110000,
                 110000, 85000, 45000, 7000, 20000, 8000, -3000, -2928, -3000, -3928};
  int IMP [20] = '{3928, 3000, 2928, 3000, -8000, -20000, -7000, -45000, -85000, -110000,
                   -110000, -85000, -45000, -7000, -20000, -8000, 3000, 2928, 3000, 3928};

  typedef struct { int y; bit ph0; } exp_t;
  exp_t   q [$];
  int     samp [$];
  longint cyc = 0;
  longint anchor = 0;

  // Output for phase p given the five most recent captured samples (newest first).
  function automatic int model_y(input int p);
    longint s = 0;
    longint t;
`ifndef UPSAMPLER_SAT_EN
    int r;
`endif
    for (int k = 0; k < 5; k++)
      if (k < samp.size()) s += longint'(H[4*k+p]) * longint'(samp[k]);
    t = s >>> 17;
`ifdef UPSAMPLER_SAT_EN
    if (t > 131071) return 131071;
    if (t < -131072) return -131072;
    return int'(t);
`else
    r = int'(t & 64'h3FFFF);
    if (r >= 131072) r -= 262144;
    return r;
`endif
  endfunction

  initial for (int i = 0; i < 5; i++) q.push_back('{0, 1'b0});

  // Outputs after edge e are whatever the filter state was after edge e-4.
  always @(posedge clk) begin : model
    exp_t e;
    cyc++;
    if (reset) begin
      foreach (q[i]) q[i] = '{0, 1'b0};
      samp.delete();
      anchor = cyc;
      e = '{0, 1'b0};
    end else begin
      if (bus.sam_clk_ena) begin
        samp.push_front(int'(bus.x_in));
        if (samp.size() > 5) void'(samp.pop_back());
        anchor = cyc;
      end
      e.y   = model_y(int'((cyc - anchor) % 4));
      e.ph0 = bus.sam_clk_ena;
    end
    q.push_back(e);
    void'(q.pop_front());
  end

  always @(negedge clk) begin
    if (chk_en) begin
      n_chk++;
      if (int'(bus.y) != q[0].y || bus.y_phase0 != q[0].ph0) begin
        n_fail++;
        $display("FAIL model @%0t: y=%0d ph0=%0b, expected y=%0d ph0=%0b",
                 $time, bus.y, bus.y_phase0, q[0].y, q[0].ph0);
      end
    end
  end

  task automatic lit(input string nm, input int act, input int expv);
    n_chk++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0d, expected %0d", nm, $time, act, expv);
    end
  endtask

  task automatic step(input bit e, input int v);
    bus.sam_clk_ena = e;
    bus.x_in = 18'(v);
    @(negedge clk);
  endtask

  task automatic impulse_run(input string tag);
    for (int j = 0; j < 28; j++) begin
      step(j % 4 == 0, (j == 0) ? -131072 : 0);
      if (j >= 4 && j < 24) begin
        lit({tag, " y"}, int'(bus.y), IMP[j-4]);
        lit({tag, " ph0"}, int'(bus.y_phase0), ((j - 4) % 4 == 0) ? 1 : 0);
      end else if (j >= 24) begin
        lit({tag, " tail"}, int'(bus.y), 0);
      end
    end
  endtask

  // Samples sign-matched to phase-1 taps so the phase-1 sum overflows.
  task automatic ovf(input int sg, input int exp_sat, input int exp_wrap);
    int pat [5];
    pat = '{-1, 1, 1, 1, -1};
    for (int i = 0; i < 5; i++) begin
      step(1'b1, sg * pat[i] * 131071);
      if (i < 4) for (int j = 0; j < 3; j++) step(1'b0, 0);
    end
    for (int j = 0; j < 5; j++) step(1'b0, 0);
`ifdef UPSAMPLER_SAT_EN
    lit("ovf sat", int'(bus.y), exp_sat);
`else
    lit("ovf wrap", int'(bus.y), exp_wrap);
`endif
  endtask

  initial begin
    int gaps [10];
    int cnt;
    logic signed [17:0] rv;
    bus.sam_clk_ena = 1'b0;
    bus.x_in = '0;
    reset = 1'b1;
    @(negedge clk);
    step(1'b0, 0);
    step(1'b0, 0);
    reset = 1'b0;
    chk_en = 1'b1;
    lit("reset y", int'(bus.y), 0);
    lit("reset ph0", int'(bus.y_phase0), 0);
    for (int j = 0; j < 4; j++) step(1'b0, 0);

    impulse_run("imp1");

    for (int j = 0; j < 8; j++) step(j % 4 == 0, (j == 0) ? -131072 : 0);
    reset = 1'b1;
    step(1'b0, 0);
    lit("midrst y", int'(bus.y), 0);
    lit("midrst ph0", int'(bus.y_phase0), 0);
    reset = 1'b0;
    for (int j = 0; j < 3; j++) step(1'b0, 0);
    impulse_run("imp2");

    for (int j = 0; j < 40; j++) begin
      step(j % 4 == 0, 65536);
      if (j >= 24) lit("dc", int'(bus.y), 65536);
    end

    gaps = '{4, 5, 4, 3, 4, 5, 5, 3, 3, 4};
    foreach (gaps[g]) begin
      rv = 18'($urandom);
      step(1'b1, int'(rv));
      for (int j = 1; j < gaps[g]; j++) step(1'b0, 0);
    end

    ovf(1, 131071, -119218);
    ovf(-1, -131072, 119217);

    cnt = 0;
    for (int j = 0; j < 3000; j++) begin
      if ($urandom_range(0, 299) == 0) begin
        reset = 1'b1;
        step(1'b0, 0);
        reset = 1'b0;
        cnt = 0;
      end else if (cnt == 0) begin
        case ($urandom_range(0, 3))
          0:       rv = 18'sd131071;
          1:       rv = -18'sd131072;
          default: rv = 18'($urandom);
        endcase
        step(1'b1, int'(rv));
        cnt = $urandom_range(2, 4);
      end else begin
        step(1'b0, int'($urandom_range(0, 1000)));
        cnt--;
      end
    end

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
